// File: rtl/ram_burst_ctrl.sv
// Burst controller driving a single-port 64x16 RAM: one access per cycle, address auto-increment.
// Optional macro RAM_BURST_CTRL_BOUND_CHK_EN rejects bursts that would run past the top of the RAM.
module ram_burst_ctrl #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 16,
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          req,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_r_w,
    output logic          ram_enable,
    output logic          ram_ce,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;
    logic          rd_valid_r;
    logic          done_r;
    logic          err_r;
    logic          write_fire;
    logic          read_fire;
    logic          out_of_range;

`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
    logic [AW:0] burst_end;
    assign burst_end    = {1'b0, req_addr} + (AW+1)'(req_len) + (AW+1)'(1);
    assign out_of_range = burst_end > {1'b1, {AW{1'b0}}};
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        write_fire  = ce && (state == WRITE) && wr_valid;
        read_fire   = ce && (state == READ);
        wr_ready    = ce && (state == WRITE);
        ram_enable  = write_fire || read_fire;
        ram_r_w     = write_fire;
        ram_add     = cur_addr;
        ram_data_in = wr_data;
        ram_ce      = ce;
        rd_data     = ram_data_out;
        rd_valid    = rd_valid_r && ce;
        done        = done_r && ce;
        err         = err_r && ce;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy       <= 1'b0;
        end else if (ce) begin
            // RAM read data appears one cycle after the READ-state access
            rd_valid_r <= (state == READ);
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            unique case (state)
                IDLE: begin
                    // a request landing on the done pulse is dropped
                    if (req && !done_r) begin
                        if (out_of_range) begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                        end else begin
                            cur_addr  <= req_addr;
                            remaining <= req_len;
                            busy      <= 1'b1;
                            state     <= req_we ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + 1'b1;
                        if (remaining == '0) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                READ: begin
                    cur_addr <= cur_addr + 1'b1;
                    if (remaining == '0) begin
                        state  <= DRAIN;
                        done_r <= 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl with a behavioural 64x16 RAM and a transaction-level reference.
// Expectations for rejected bursts follow RAM_BURST_CTRL_BOUND_CHK_EN when it is defined.
module tb_ram_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        req;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [3:0]  req_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  ram_add;
    logic [15:0] ram_data_in;
    logic        ram_r_w;
    logic        ram_enable;
    logic        ram_ce;
    logic [15:0] ram_data_out;

    ram_burst_ctrl #(.AW(6), .DW(16), .LW(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_r_w(ram_r_w),
        .ram_enable(ram_enable), .ram_ce(ram_ce), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, gated by ce and enable
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (ram_ce && ram_enable) begin
            if (ram_r_w) mem[ram_add] <= ram_data_in;
            else         ram_data_out <= mem[ram_add];
        end
    end

    // Reference contents: what the RAM should hold after the bursts issued so far
    logic [15:0] ref_mem [64];
    bit          ref_vld [64];

    int n_checks  = 0;
    int n_errors  = 0;
    int pin_viol  = 0;
    int err_cnt   = 0;
    int exp_err   = 0;

    logic [5:0]  wa [$];
    logic [15:0] wd [$];
    logic [5:0]  ra [$];

    always @(negedge clk) begin
        if (ram_ce !== ce) pin_viol++;
        if (ram_data_in !== wr_data) pin_viol++;
        if (rd_data !== ram_data_out) pin_viol++;
        if (!ram_enable && ram_r_w) pin_viol++;
        if (!ce && (ram_enable || wr_ready || rd_valid || done || err)) pin_viol++;
        if (ram_enable === 1'b1 && ram_r_w === 1'b1) begin
            wa.push_back(ram_add);
            wd.push_back(ram_data_in);
        end
        if (ram_enable === 1'b1 && ram_r_w === 1'b0) ra.push_back(ram_add);
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // gap_mode: 0 continuous, 1 alternating 1,0,1,..., 2 random
    task automatic write_burst(input logic [5:0] addr, input int len, input int gap_mode,
                               input bit seq, input logic [15:0] base, input bit noise);
        logic [15:0] d [$];
        int idx = 0;
        int cyc = 0;
        int wbase;
        bit acc;
        logic [5:0] a;
        for (int i = 0; i < len; i++) d.push_back(seq ? base + 16'(i) : 16'($urandom));
        wbase = wa.size();
        req = 1'b1; req_we = 1'b1; req_addr = addr; req_len = 4'(len - 1);
        @(posedge clk); #1;
        req = 1'b0;
        while (idx < len && cyc < 300) begin
            case (gap_mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = (cyc % 2 == 0);
                default: wr_valid = 1'($urandom);
            endcase
            wr_data = d[idx];
            if (noise) begin
                req = 1'b1; req_we = 1'($urandom); req_addr = 6'($urandom); req_len = 4'($urandom);
            end
            @(negedge clk);
            if (cyc == 0) check("wr_busy_start", busy, 1);
            acc = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        wr_valid = 1'b0;
        req = 1'b0;
        check("wr_words_accepted", idx, len);
        if (noise) begin
            req = 1'b1; req_we = 1'($urandom); req_addr = 6'($urandom); req_len = 4'($urandom);
        end
        @(negedge clk);
        check("wr_done_pulse", done, 1);
        check("wr_busy_at_done", busy, 0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("wr_done_cleared", done, 0);
        check("wr_req_on_done_ignored", busy, 0);
        @(posedge clk); #1;
        check("wr_access_cnt", wa.size() - wbase, len);
        for (int i = 0; i < len && wbase + i < wa.size(); i++) begin
            a = addr + 6'(i);
            check("wr_addr", wa[wbase + i], a);
            check("wr_data", wd[wbase + i], d[i]);
        end
        for (int i = 0; i < len; i++) begin
            a = addr + 6'(i);
            ref_mem[a] = d[i];
            ref_vld[a] = 1'b1;
        end
    endtask

    task automatic read_burst(input logic [5:0] addr, input int len, input int stall_k,
                              input int stall_n, input bit noise);
        logic [15:0] got [$];
        int first_k = -1;
        int last_k  = -1;
        int done_k  = -1;
        int rbase;
        int total;
        int exp_first;
        logic [5:0] a;
        rbase = ra.size();
        total = len + 3 + stall_n;
        req = 1'b1; req_we = 1'b0; req_addr = addr; req_len = 4'(len - 1);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 1; k <= total; k++) begin
            ce = !(stall_k != 0 && k >= stall_k && k < stall_k + stall_n);
            if (noise && k <= len + 1 + stall_n) begin
                req = 1'b1; req_we = 1'($urandom); req_addr = 6'($urandom); req_len = 4'($urandom);
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (k == 1) check("rd_busy_start", busy, 1);
            if (rd_valid) begin
                got.push_back(rd_data);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) done_k = k;
            if (k == total) check("rd_busy_end", busy, 0);
            @(posedge clk); #1;
        end
        ce = 1'b1;
        req = 1'b0;
        exp_first = (stall_k == 2) ? 2 + stall_n : 2;
        check("rd_valid_cnt", got.size(), len);
        check("rd_first_cycle", first_k, exp_first);
        check("rd_last_cycle", last_k, len + 1 + stall_n);
        check("rd_done_cycle", done_k, len + 1 + stall_n);
        for (int i = 0; i < len && i < got.size(); i++) begin
            a = addr + 6'(i);
            if (ref_vld[a]) check("rd_data", got[i], ref_mem[a]);
        end
        check("rd_access_cnt", ra.size() - rbase, len);
        for (int i = 0; i < len && rbase + i < ra.size(); i++) begin
            a = addr + 6'(i);
            check("rd_addr", ra[rbase + i], a);
        end
    endtask

`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
    task automatic reject_burst(input logic [5:0] addr, input int len);
        int rbase;
        int wbase;
        rbase = ra.size();
        wbase = wa.size();
        req = 1'b1; req_we = 1'($urandom); req_addr = addr; req_len = 4'(len - 1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("rej_err", err, 1);
        check("rej_done", done, 1);
        check("rej_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rej_err_cleared", err, 0);
        check("rej_still_idle", busy, 0);
        @(posedge clk); #1;
        check("rej_no_access", (ra.size() - rbase) + (wa.size() - wbase), 0);
        exp_err++;
    endtask
`endif

    task automatic reset_mid_read();
        int n = 0;
        int cyc = 0;
        req = 1'b1; req_we = 1'b0; req_addr = 6'h10; req_len = 4'd7;
        @(posedge clk); #1;
        req = 1'b0;
        while (n < 3 && cyc < 20) begin
            @(negedge clk);
            if (rd_valid) n++;
            if (n == 3) rst = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b0;
        check("rst_third_word_seen", n, 3);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ram_enable", ram_enable, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_stays_idle", {busy, ram_enable, rd_valid}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] a;
        int len;
        int sk;
        int sn;
        rst = 1'b1; ce = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outputs", {rd_valid, done, err, wr_ready, ram_enable}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        write_burst(6'h05, 4, 0, 1'b1, 16'hA000, 1'b0);
        read_burst(6'h05, 4, 0, 0, 1'b0);
        read_burst(6'h06, 1, 0, 0, 1'b0);
        write_burst(6'h00, 3, 1, 1'b0, 16'h0, 1'b0);
        read_burst(6'h00, 3, 0, 0, 1'b0);
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
        reject_burst(6'h3E, 4);
`else
        write_burst(6'h3E, 4, 0, 1'b1, 16'hB000, 1'b0);
        read_burst(6'h3E, 4, 0, 0, 1'b0);
`endif
        write_burst(6'h20, 16, 2, 1'b0, 16'h0, 1'b0);
        read_burst(6'h20, 16, 9, 5, 1'b0);
        write_burst(6'h30, 5, 2, 1'b0, 16'h0, 1'b1);
        read_burst(6'h30, 5, 0, 0, 1'b1);
        reset_mid_read();

        for (int t = 0; t < 40; t++) begin
            a   = 6'($urandom);
            len = $urandom_range(1, 16);
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
            if (int'(a) + len > 64) begin
                reject_burst(a, len);
                continue;
            end
`endif
            if ($urandom_range(0, 1) == 1) begin
                write_burst(a, len, 2, 1'b0, 16'h0, 1'($urandom));
            end else begin
                sk = 0;
                sn = 0;
                if ($urandom_range(0, 2) == 0) begin
                    sk = $urandom_range(2, len + 1);
                    sn = $urandom_range(1, 4);
                end
                read_burst(a, len, sk, sn, 1'($urandom));
            end
        end

        check("pin_rules", pin_viol, 0);
        check("err_pulses", err_cnt, exp_err);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Memory-access controller sitting directly upstream of the single-port 64x16 data RAM; sole driver of its address, data, r_w, enable and ce pins.
- Converts CPU-side burst requests (1..16 words, read or write) into one RAM access per cycle, with address auto-increment.
- Returns read data with a valid strobe, accounting for the RAM's 1-cycle registered read latency.

Parameters:
- AW, 6, RAM address width (64 words).
- DW, 16, data word width.
- LW, 4, burst length field width; burst = req_len+1 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  global clock enable; forwarded to RAM.
- req  in  1  burst request; sampled only in IDLE.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  AW  start address.
- req_len  in  LW  words minus one.
- wr_data  in  DW  write word.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  controller accepts a write word this cycle.
- rd_data  out  DW  read word (wired from ram_data_out).
- rd_valid  out  1  rd_data valid; no backpressure.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse on rejected request (see Optional Feature).
- ram_add  out  AW  to RAM add.
- ram_data_in  out  DW  to RAM data_in.
- ram_r_w  out  1  to RAM r_w (0 read, 1 write).
- ram_enable  out  1  to RAM enable.
- ram_ce  out  1  to RAM ce (= ce).
- ram_data_out  in  DW  from RAM data_out.

Behaviour:
- Reset: state IDLE, cur_addr=0, remaining=0, rd_valid=0, done=0, err=0, busy=0. Reset wins over ce and req, and aborts any burst mid-transfer. RAM contents are untouched; no further RAM accesses.
- ce=0 freezes all registers.
  - ram_enable, wr_ready, rd_valid, done and err are forced 0 while ce=0.
  - Frozen state resumes unchanged when ce returns.
- States:
  - IDLE: busy=0. On req=1, latch cur_addr=req_addr and remaining=req_len; go to WRITE if req_we else READ. busy=1 from the next cycle.
  - WRITE: wr_ready=1. On wr_valid: ram_enable=1, ram_r_w=1, ram_add=cur_addr, ram_data_in=wr_data, all combinational in the same cycle. cur_addr++. If remaining==0 go to IDLE with done=1 the next cycle, else remaining--. Without wr_valid: no access, state holds indefinitely.
  - READ: ram_enable=1, ram_r_w=0, ram_add=cur_addr every cycle. cur_addr++. If remaining==0 go to DRAIN, else remaining--.
  - DRAIN: last read word is valid; done=1 this cycle; next state IDLE.
- rd_valid is a flop set to 1 the cycle after each READ-state access; rd_data=ram_data_out. An N-word read yields N consecutive rd_valid cycles, starting 2 cycles after the req cycle.
- Address arithmetic is modulo 64: 63 increments to 0.
- req while busy is ignored. req in the same cycle as done/DRAIN is ignored; the next request is accepted from IDLE one cycle later.
- ram_data_in is driven with wr_data and ram_r_w=0 whenever no write is issued.
- Outside WRITE/READ, ram_enable=0.

Optional Feature:
- Macro: RAM_BURST_CTRL_BOUND_CHK_EN.
- Defined: in IDLE, a request with req_addr+req_len+1 > 64 is rejected. No RAM access occurs, state stays IDLE, and err=1 and done=1 pulse together the next cycle.
- Undefined: bursts wrap 63->0 and err is tied 0.

Test Plan:
- Reset mid-burst: start an 8-word read at 0x10, assert rst on the 3rd rd_valid -> next cycle busy=0, rd_valid=0, ram_enable=0, state IDLE.
- Write 4 words 0xA000..0xA003 at 0x05 with wr_valid continuous, then read 4 at 0x05 -> rd_valid high exactly 4 cycles, data 0xA000..0xA003 in order, done coincident with the last word.
- Write 3 words at 0x00 with wr_valid gaps (1,0,1,0,1) -> exactly 3 RAM writes to 0x00..0x02, done 1 cycle after the 3rd accepted word.
- Wrap: without the macro, write 4 words at 0x3E -> RAM writes to 0x3E, 0x3F, 0x00, 0x01. With RAM_BURST_CTRL_BOUND_CHK_EN, the same request -> err=1 and done=1 one cycle, zero RAM accesses.
- ce stall: during a 16-word read drop ce for 5 cycles at word 7 -> no rd_valid, no RAM accesses while low; after resume, words 7..15 follow correctly with no duplicates or losses.
- req asserted while busy with different addr/we -> ignored; the current burst completes unchanged.
